wb_sram_dual_port: RTL and testbench

//  True dual-port synchronous SRAM with two independent Wishbone-like slave ports, A and B.

---
 rtl/wb_sram_dual_port.sv | 85 ++++++++
 tb/tb_wb_sram_dual_port.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_dual_port.sv
// True dual-port SRAM, two Wishbone-like slave ports; WB_SRAM_DP_BYPASS_EN enables write-first forwarding.
// Latency: ack and read data registered, exactly one cycle after each accepted strobe.
// Backpressure: none; every strobe is accepted, one beat per cycle per port.
module wb_sram_dual_port #(
  parameter int WIDTH = 8,
  parameter int SBITS = 12,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_cyc_i,
  input  logic             a_stb_i,
  input  logic             a_we_i,
  input  logic             a_bst_i,
  output logic             a_ack_o,
  input  logic [SBITS-1:0] a_adr_i,
  input  logic [WIDTH-1:0] a_dat_i,
  output logic [WIDTH-1:0] a_dat_o,
  input  logic             b_cyc_i,
  input  logic             b_stb_i,
  input  logic             b_we_i,
  input  logic             b_bst_i,
  output logic             b_ack_o,
  input  logic [SBITS-1:0] b_adr_i,
  input  logic [WIDTH-1:0] b_dat_i,
  output logic [WIDTH-1:0] b_dat_o
);
  localparam int SIZE = 1 << SBITS;

  logic [WIDTH-1:0] mem [SIZE];

  logic             a_acc, b_acc, a_wr, b_wr, a_rd, b_rd;
  logic [WIDTH-1:0] a_rd_word, b_rd_word;
  logic             a_ack_d, a_ack_q, b_ack_d, b_ack_q;
  logic [WIDTH-1:0] a_dat_d, a_dat_q, b_dat_d, b_dat_q;

  // Burst hint carries no timing meaning and the output delay applies to simulation only.
  logic unused_ok;
  assign unused_ok = ^{a_bst_i, b_bst_i, DELAY[0]};

  always_comb begin
    a_acc     = a_cyc_i & a_stb_i & ~rst_i;
    b_acc     = b_cyc_i & b_stb_i & ~rst_i;
    a_wr      = a_acc & a_we_i;
    b_wr      = b_acc & b_we_i;
    a_rd      = a_acc & ~a_we_i;
    b_rd      = b_acc & ~b_we_i;
    a_rd_word = mem[a_adr_i];
    b_rd_word = mem[b_adr_i];
`ifdef WB_SRAM_DP_BYPASS_EN
    // A reading port never writes, so the forwarded word is always the other port's.
    if (b_wr && (b_adr_i == a_adr_i)) a_rd_word = b_dat_i;
    if (a_wr && (a_adr_i == b_adr_i)) b_rd_word = a_dat_i;
`endif
    a_ack_d = a_acc;
    b_ack_d = b_acc;
    a_dat_d = a_rd ? a_rd_word : a_dat_q;
    b_dat_d = b_rd ? b_rd_word : b_dat_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_dat_q <= '0;
      b_dat_q <= '0;
    end else begin
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      a_dat_q <= a_dat_d;
      b_dat_q <= b_dat_d;
    end
  end

  // Port A's write is issued last so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (b_wr) mem[b_adr_i] <= b_dat_i;
    if (a_wr) mem[a_adr_i] <= a_dat_i;
  end

  assign a_ack_o = a_ack_q;
  assign b_ack_o = b_ack_q;
  assign a_dat_o = a_dat_q;
  assign b_dat_o = b_dat_q;
endmodule

// File: tb/tb_wb_sram_dual_port.sv
// Randomised scoreboard bench for wb_sram_dual_port: directed scenarios then random dual-port traffic.
module tb_wb_sram_dual_port;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_cyc_i = 1'b0, a_stb_i = 1'b0, a_we_i = 1'b0, a_bst_i = 1'b0;
  logic        b_cyc_i = 1'b0, b_stb_i = 1'b0, b_we_i = 1'b0, b_bst_i = 1'b0;
  logic [11:0] a_adr_i = '0, b_adr_i = '0;
  logic [7:0]  a_dat_i = '0, b_dat_i = '0;
  logic        a_ack_o, b_ack_o;
  logic [7:0]  a_dat_o, b_dat_o;

  wb_sram_dual_port #(.WIDTH(8), .SBITS(12), .DELAY(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_bst_i(a_bst_i),
    .a_ack_o(a_ack_o), .a_adr_i(a_adr_i), .a_dat_i(a_dat_i), .a_dat_o(a_dat_o),
    .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_bst_i(b_bst_i),
    .b_ack_o(b_ack_o), .b_adr_i(b_adr_i), .b_dat_i(b_dat_i), .b_dat_o(b_dat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        cyc, stb, we, bst;
    logic [11:0] adr;
    logic [7:0]  dat;
  } port_t;

  typedef struct {
    int         due;
    logic       ack;
    logic [7:0] dat;
  } exp_t;

  exp_t       qa[$], qb[$];
  logic [7:0] mem_m [int];
  logic [7:0] hold_a = '0, hold_b = '0;
  int         cyc_cnt = 0;
  int         checks = 0, failures = 0;

  always @(posedge clk_i) cyc_cnt++;

  function automatic port_t idle();
    port_t p;
    p.cyc = 0; p.stb = 0; p.we = 0; p.bst = 0; p.adr = '0; p.dat = '0;
    return p;
  endfunction

  function automatic port_t hold();
    port_t p = idle();
    p.cyc = 1;
    return p;
  endfunction

  function automatic port_t wr(input logic [11:0] adr, input logic [7:0] dat, input logic bst);
    port_t p = idle();
    p.cyc = 1; p.stb = 1; p.we = 1; p.bst = bst; p.adr = adr; p.dat = dat;
    return p;
  endfunction

  function automatic port_t rd(input logic [11:0] adr, input logic bst);
    port_t p = idle();
    p.cyc = 1; p.stb = 1; p.bst = bst; p.adr = adr;
    return p;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_cnt, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [11:0] adr);
    if (!mem_m.exists(int'(adr))) begin
      $display("FAIL bench_read_unwritten adr %0h: got none expected written word", adr);
      failures++;
      return 8'h00;
    end
    return mem_m[int'(adr)];
  endfunction

  // One clock of stimulus; the model applies reads on old contents, then B's write, then A's.
  task automatic step(input logic rst, input port_t pa, input port_t pb);
    logic acc_a, acc_b;
    logic [7:0] v;
    exp_t e;
    @(posedge clk_i); #1;
    rst_i = rst;
    a_cyc_i = pa.cyc; a_stb_i = pa.stb; a_we_i = pa.we; a_bst_i = pa.bst; a_adr_i = pa.adr; a_dat_i = pa.dat;
    b_cyc_i = pb.cyc; b_stb_i = pb.stb; b_we_i = pb.we; b_bst_i = pb.bst; b_adr_i = pb.adr; b_dat_i = pb.dat;
    acc_a = pa.cyc & pa.stb & ~rst;
    acc_b = pb.cyc & pb.stb & ~rst;
    if (acc_a && !pa.we) begin
      v = model_read(pa.adr);
`ifdef WB_SRAM_DP_BYPASS_EN
      if (acc_b && pb.we && pb.adr == pa.adr) v = pb.dat;
`endif
      hold_a = v;
    end
    if (acc_b && !pb.we) begin
      v = model_read(pb.adr);
`ifdef WB_SRAM_DP_BYPASS_EN
      if (acc_a && pa.we && pa.adr == pb.adr) v = pa.dat;
`endif
      hold_b = v;
    end
    if (rst) begin
      hold_a = '0;
      hold_b = '0;
    end
    if (acc_b && pb.we) mem_m[int'(pb.adr)] = pb.dat;
    if (acc_a && pa.we) mem_m[int'(pa.adr)] = pa.dat;
    e.due = cyc_cnt + 1; e.ack = acc_a; e.dat = hold_a; qa.push_back(e);
    e.due = cyc_cnt + 1; e.ack = acc_b; e.dat = hold_b; qb.push_back(e);
  endtask

  // Monitor: compares ack and held read data on every cycle an expectation falls due.
  always @(negedge clk_i) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].due < cyc_cnt) begin
      e = qa.pop_front();
      cmp("a_stale", 8'(cyc_cnt), 8'(e.due));
    end
    while (qb.size() > 0 && qb[0].due < cyc_cnt) begin
      e = qb.pop_front();
      cmp("b_stale", 8'(cyc_cnt), 8'(e.due));
    end
    if (qa.size() > 0 && qa[0].due == cyc_cnt) begin
      e = qa.pop_front();
      cmp("a_ack", 8'(a_ack_o), 8'(e.ack));
      cmp("a_dat", a_dat_o, e.dat);
    end
    if (qb.size() > 0 && qb[0].due == cyc_cnt) begin
      e = qb.pop_front();
      cmp("b_ack", 8'(b_ack_o), 8'(e.ack));
      cmp("b_dat", b_dat_o, e.dat);
    end
  end

  initial begin
    port_t pa, pb;
    logic  rst;
    // Reset held 4 cycles with both ports trying to write
    for (int i = 0; i < 4; i++) step(1'b1, wr(12'h123, 8'hEE, 0), wr(12'h124, 8'hDD, 0));
    // Writes during reset must be suppressed on a word with known contents
    step(1'b0, wr(12'h055, 8'h77, 0), idle());
    step(1'b0, hold(), idle());
    step(1'b1, wr(12'h055, 8'h99, 0), wr(12'h055, 8'h98, 0));
    step(1'b1, wr(12'h055, 8'h99, 0), wr(12'h055, 8'h98, 0));
    step(1'b0, idle(), rd(12'h055, 0));
    step(1'b0, idle(), hold());
    // Single write then read on B
    step(1'b0, idle(), wr(12'h123, 8'hA5, 0));
    step(1'b0, idle(), hold());
    step(1'b0, idle(), idle());
    step(1'b0, idle(), rd(12'h123, 0));
    step(1'b0, idle(), hold());
    step(1'b0, idle(), idle());
    // 16-beat burst write across 0x7FF/0x800, then two back-to-back 8-beat reads
    for (int i = 0; i < 16; i++) step(1'b0, idle(), wr(12'h7F8 + 12'(i), 8'($urandom), i != 15));
    step(1'b0, idle(), hold());
    for (int i = 0; i < 16; i++) step(1'b0, idle(), rd(12'h7F8 + 12'(i), (i % 8) != 7));
    step(1'b0, idle(), hold());
    step(1'b0, idle(), idle());
    // Cross-port write then read, and concurrent reads of different words
    step(1'b0, wr(12'h010, 8'h3C, 0), idle());
    step(1'b0, hold(), idle());
    step(1'b0, idle(), rd(12'h010, 0));
    step(1'b0, rd(12'h123, 0), rd(12'h7F9, 0));
    step(1'b0, hold(), hold());
    // Same-address write collision: A's data wins
    step(1'b0, wr(12'h020, 8'h11, 0), wr(12'h020, 8'h22, 0));
    step(1'b0, rd(12'h020, 0), rd(12'h020, 0));
    // A writes while B reads the same word in the same cycle
    step(1'b0, wr(12'h030, 8'h00, 0), idle());
    step(1'b0, wr(12'h030, 8'h55, 0), rd(12'h030, 0));
    step(1'b0, idle(), rd(12'h030, 0));
    // B writes while A reads the same word
    step(1'b0, rd(12'h030, 0), wr(12'h030, 8'h66, 0));
    step(1'b0, rd(12'h030, 0), idle());
    step(1'b0, idle(), idle());
    // Reset in the middle of an 8-beat B read, with A attempting a write
    for (int i = 0; i < 8; i++) begin
      rst = (i == 4);
      step(rst, rst ? wr(12'h7F8, 8'hFF, 0) : idle(), rd(12'h7F8 + 12'(i), 1));
    end
    step(1'b0, idle(), idle());
    for (int i = 0; i < 8; i++) step(1'b0, idle(), rd(12'h7F8 + 12'(i), i != 7));
    step(1'b0, idle(), hold());
    // Address wrap at the top of the array
    step(1'b0, wr(12'hFFF, 8'h5A, 0), wr(12'h000, 8'hA6, 0));
    step(1'b0, rd(12'h000, 0), rd(12'hFFF, 0));
    // Fill a small window, then random traffic on both ports
    for (int i = 0; i < 8; i++) step(1'b0, wr(12'h3F0 + 12'(i), 8'($urandom), 1), idle());
    for (int n = 0; n < 400; n++) begin
      pa = idle(); pb = idle();
      pa.cyc = ($urandom % 5) != 0; pa.stb = pa.cyc & (($urandom % 3) != 0);
      pa.we = $urandom % 2; pa.bst = $urandom % 2;
      pa.adr = 12'h3F0 + 12'($urandom % 8); pa.dat = 8'($urandom);
      pb.cyc = ($urandom % 5) != 0; pb.stb = pb.cyc & (($urandom % 3) != 0);
      pb.we = $urandom % 2; pb.bst = $urandom % 2;
      pb.adr = 12'h3F0 + 12'($urandom % 8); pb.dat = 8'($urandom);
      rst = ($urandom % 40) == 0;
      step(rst, pa, pb);
    end
    step(1'b0, idle(), idle());
    step(1'b0, idle(), idle());
    repeat (4) @(negedge clk_i);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
